// File: rtl/mcpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: states, opcodes,
// funct codes, ALU operations, mux selects and trap causes.
package mcpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_TRAP = 3'd7
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;

    localparam logic       SRCA_PC  = 1'b0;
    localparam logic       SRCA_A   = 1'b1;
    localparam logic [1:0] SRCB_B   = 2'd0;
    localparam logic [1:0] SRCB_4   = 2'd1;
    localparam logic [1:0] SRCB_IMM = 2'd2;
    localparam logic [1:0] SRCB_BR  = 2'd3;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MEM    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS     = 2'b10;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_XORI: ok = 1'b1;
            OP_R: ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_SLT) || (fn == FN_JR);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] rtype_alu_op(input logic [5:0] fn);
        logic [2:0] op;
        case (fn)
            FN_SUB:  op = ALU_SUB;
            FN_SLT:  op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mcpu_wait_timer.sv
// Memory wait-cycle counter: clears on request, counts stalled cycles and flags
// the last allowed wait cycle. TIMEOUT = 0 never expires.
module mcpu_wait_timer #(
    parameter int TMR_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle MIPS-subset controller: registered state, combinational datapath
// controls, memory handshake with timeout, sticky trap and retired counter.
module mcpu_ctrl_fsm
    import mcpu_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int TMR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             alu_zero,
    input  logic             mem_ack,
    output logic             pc_we,
    output logic             ir_we,
    output logic             aluout_we,
    output logic             a_we,
    output logic             b_we,
    output logic             iord,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             imm_zext,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic [2:0]       state,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired_cnt
);

    state_e            state_q, state_d;
    logic              trap_q, trap_d;
    logic [1:0]        cause_q, cause_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              tmr_inc;
    logic              tmr_clr;
    logic              tmr_expired;
    logic              retire;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_instr_bits;

    assign opcode            = instr[31:26];
    assign funct             = instr[5:0];
    assign unused_instr_bits = ^instr[25:6];

    always_comb begin
        state_d   = state_q;
        trap_d    = trap_q;
        cause_d   = cause_q;
        tmr_inc   = 1'b0;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        aluout_we = 1'b0;
        a_we      = 1'b0;
        b_we      = 1'b0;
        iord      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        reg_we    = 1'b0;
        reg_dst   = DST_RT;
        wb_sel    = WB_ALUOUT;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_B;
        imm_zext  = 1'b0;
        alu_op    = ALU_ADD;
        pc_src    = PC_ALU;

        case (state_q)
            ST_IF: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_4;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_ID;
                end else if (tmr_expired) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_BUS;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ST_ID: begin
                // Branch target is computed speculatively into ALUOut.
                alu_src_b = SRCB_BR;
                if (!is_legal(opcode, funct)) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    a_we      = 1'b1;
                    b_we      = 1'b1;
                    aluout_we = 1'b1;
                    if (opcode == OP_J) begin
                        pc_we   = 1'b1;
                        pc_src  = PC_JUMP;
                        state_d = ST_IF;
                    end else begin
                        state_d = ST_EX;
                    end
                end
            end
            ST_EX: begin
                case (opcode)
                    OP_LW, OP_SW: begin
                        alu_src_a = SRCA_A;
                        alu_src_b = SRCB_IMM;
                        aluout_we = 1'b1;
                        state_d   = ST_MEM;
                    end
                    OP_R: begin
                        if (funct == FN_JR) begin
                            pc_we   = 1'b1;
                            pc_src  = PC_REG;
                            state_d = ST_IF;
                        end else begin
                            alu_src_a = SRCA_A;
                            alu_op    = rtype_alu_op(funct);
                            aluout_we = 1'b1;
                            state_d   = ST_WB;
                        end
                    end
                    OP_ADDI, OP_XORI: begin
                        alu_src_a = SRCA_A;
                        alu_src_b = SRCB_IMM;
                        imm_zext  = (opcode == OP_XORI);
                        alu_op    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
                        aluout_we = 1'b1;
                        state_d   = ST_WB;
                    end
                    OP_BEQ, OP_BNE: begin
                        alu_src_a = SRCA_A;
                        alu_op    = ALU_SUB;
                        pc_we     = (opcode == OP_BEQ) ? alu_zero : !alu_zero;
                        pc_src    = PC_ALUOUT;
                        state_d   = ST_IF;
                    end
                    OP_JAL: begin
                        reg_we  = 1'b1;
                        reg_dst = DST_RA;
                        wb_sel  = WB_PC;
                        pc_we   = 1'b1;
                        pc_src  = PC_JUMP;
                        state_d = ST_IF;
                    end
                    default: begin
                        // IR changed under us after decode; treat as illegal.
                        state_d = ST_TRAP;
                        trap_d  = 1'b1;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (opcode == OP_SW);
                if (mem_ack) begin
                    state_d = (opcode == OP_SW) ? ST_IF : ST_WB;
                end else if (tmr_expired) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_BUS;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ST_WB: begin
                reg_we = 1'b1;
                if (opcode == OP_LW) begin
                    wb_sel = WB_MEM;
                end else if (opcode == OP_R) begin
                    reg_dst = DST_RD;
                end
                state_d = ST_IF;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_IF;
            end
        endcase

        // Reset abandons any in-flight request or write immediately.
        if (reset) begin
            pc_we     = 1'b0;
            ir_we     = 1'b0;
            aluout_we = 1'b0;
            a_we      = 1'b0;
            b_we      = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            reg_we    = 1'b0;
        end
    end

    assign retire    = (state_d == ST_IF) &&
                       (state_q inside {ST_ID, ST_EX, ST_MEM, ST_WB});
    assign retired_d = retired_q + CNT_W'(retire);
    assign tmr_clr   = (state_d != state_q) || mem_ack;

    mcpu_wait_timer #(
        .TMR_W   (TMR_W),
        .TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmr_clr),
        .inc     (tmr_inc),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IF;
            trap_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
        end
    end

    assign state       = state_q;
    assign trap        = trap_q;
    assign trap_cause  = cause_q;
    assign retired_cnt = retired_q;

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Directed bench for mcpu_ctrl_fsm: per-cycle expected state/controls/counters are
// queued as stimulus is driven and checked at the falling edge.
module tb_mcpu_ctrl_fsm;

    localparam int S_IF = 0, S_ID = 1, S_EX = 2, S_MEM = 3, S_WB = 4, S_TRAP = 7;

    // Control word: {pc_we, ir_we, aluout_we, a_we, b_we, iord, mem_req, mem_we,
    //                reg_we, reg_dst, wb_sel, alu_src_a, alu_src_b, imm_zext, alu_op, pc_src}
    function automatic logic [21:0] cw(input int pcw, input int irw, input int aow, input int abw,
                                       input int io, input int mrq, input int mwe, input int rwe,
                                       input int dst, input int wb, input int sa, input int sb,
                                       input int zx, input int op, input int ps);
        return {pcw[0], irw[0], aow[0], abw[0], abw[0], io[0], mrq[0], mwe[0], rwe[0],
                dst[1:0], wb[1:0], sa[0], sb[1:0], zx[0], op[2:0], ps[1:0]};
    endfunction

    localparam logic [21:0] FULL      = '1;
    localparam logic [21:0] C_ZERO    = '0;
    localparam logic [21:0] ENMASK    = cw(1,1,1,1,0,1,1,1,0,0,0,0,0,0,0);
    localparam logic [21:0] C_IF_W    = cw(0,0,0,0,0,1,0,0,0,0,0,1,0,0,0);
    localparam logic [21:0] C_IF_A    = cw(1,1,0,0,0,1,0,0,0,0,0,1,0,0,0);
    localparam logic [21:0] C_ID      = cw(0,0,1,1,0,0,0,0,0,0,0,3,0,0,0);
    localparam logic [21:0] C_ID_J    = cw(1,0,1,1,0,0,0,0,0,0,0,3,0,0,2);
    localparam logic [21:0] C_EX_ADDR = cw(0,0,1,0,0,0,0,0,0,0,1,2,0,0,0);
    localparam logic [21:0] C_EX_XORI = cw(0,0,1,0,0,0,0,0,0,0,1,2,1,2,0);
    localparam logic [21:0] C_EX_ADD  = cw(0,0,1,0,0,0,0,0,0,0,1,0,0,0,0);
    localparam logic [21:0] C_EX_SUB  = cw(0,0,1,0,0,0,0,0,0,0,1,0,0,1,0);
    localparam logic [21:0] C_EX_SLT  = cw(0,0,1,0,0,0,0,0,0,0,1,0,0,3,0);
    localparam logic [21:0] C_EX_BR_T = cw(1,0,0,0,0,0,0,0,0,0,1,0,0,1,1);
    localparam logic [21:0] C_EX_BR_N = cw(0,0,0,0,0,0,0,0,0,0,1,0,0,1,1);
    localparam logic [21:0] C_EX_JR   = cw(1,0,0,0,0,0,0,0,0,0,0,0,0,0,3);
    localparam logic [21:0] C_EX_JAL  = cw(1,0,0,0,0,0,0,1,2,2,0,0,0,0,2);
    localparam logic [21:0] C_MEM_LD  = cw(0,0,0,0,1,1,0,0,0,0,0,0,0,0,0);
    localparam logic [21:0] C_MEM_ST  = cw(0,0,0,0,1,1,1,0,0,0,0,0,0,0,0);
    localparam logic [21:0] C_WB_LW   = cw(0,0,0,0,0,0,0,1,0,1,0,0,0,0,0);
    localparam logic [21:0] C_WB_I    = cw(0,0,0,0,0,0,0,1,0,0,0,0,0,0,0);
    localparam logic [21:0] C_WB_R    = cw(0,0,0,0,0,0,0,1,1,0,0,0,0,0,0);

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, J = 6'b000010, JAL = 6'b000011;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000, XORI = 6'b001110;
    localparam logic [5:0] RT = 6'b000000;

    logic        clk, reset, alu_zero, mem_ack;
    logic [31:0] instr;
    logic        pc_we, ir_we, aluout_we, a_we, b_we, iord, mem_req, mem_we, reg_we;
    logic [1:0]  reg_dst, wb_sel, alu_src_b, pc_src, trap_cause;
    logic        alu_src_a, imm_zext, trap;
    logic [2:0]  alu_op, state;
    logic [3:0]  retired_cnt;
    logic [21:0] obs_ctl;

    typedef struct {
        logic [95:0] tag;
        logic [2:0]  st;
        logic [21:0] ctl;
        logic [21:0] mask;
        logic [3:0]  ret;
        logic        trp;
        logic [1:0]  cause;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_ret;
    logic       exp_trap;
    logic [1:0] exp_cause;

    mcpu_ctrl_fsm #(.CNT_W(4), .MEM_TIMEOUT(4), .TMR_W(8)) dut (
        .clk(clk), .reset(reset), .instr(instr), .alu_zero(alu_zero), .mem_ack(mem_ack),
        .pc_we(pc_we), .ir_we(ir_we), .aluout_we(aluout_we), .a_we(a_we), .b_we(b_we),
        .iord(iord), .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we), .reg_dst(reg_dst),
        .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_zext(imm_zext),
        .alu_op(alu_op), .pc_src(pc_src), .state(state), .trap(trap),
        .trap_cause(trap_cause), .retired_cnt(retired_cnt)
    );

    assign obs_ctl = {pc_we, ir_we, aluout_we, a_we, b_we, iord, mem_req, mem_we, reg_we,
                      reg_dst, wb_sel, alu_src_a, alu_src_b, imm_zext, alu_op, pc_src};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            assert (state === mon_e.st) else begin
                errors++;
                $error("FAIL %s state: got %0d exp %0d", mon_e.tag, state, mon_e.st);
            end
            checks++;
            assert ((obs_ctl & mon_e.mask) === (mon_e.ctl & mon_e.mask)) else begin
                errors++;
                $error("FAIL %s ctl: got %h exp %h mask %h", mon_e.tag, obs_ctl, mon_e.ctl, mon_e.mask);
            end
            checks++;
            assert (retired_cnt === mon_e.ret) else begin
                errors++;
                $error("FAIL %s retired: got %0d exp %0d", mon_e.tag, retired_cnt, mon_e.ret);
            end
            checks++;
            assert (trap === mon_e.trp) else begin
                errors++;
                $error("FAIL %s trap: got %b exp %b", mon_e.tag, trap, mon_e.trp);
            end
            checks++;
            assert (trap_cause === mon_e.cause) else begin
                errors++;
                $error("FAIL %s cause: got %b exp %b", mon_e.tag, trap_cause, mon_e.cause);
            end
        end
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
        return {op, 5'd1, 5'd2, 5'd3, 5'd0, fn};
    endfunction

    // One clock cycle: queue what this cycle must show, drive inputs, advance.
    task automatic cyc(input logic rst, input logic ack, input logic z, input int st,
                       input logic [21:0] c, input logic [21:0] m, input logic [95:0] tag);
        exp_t e;
        e.tag = tag; e.st = st[2:0]; e.ctl = c; e.mask = m;
        e.ret = exp_ret; e.trp = exp_trap; e.cause = exp_cause;
        sb_q.push_back(e);
        reset = rst; mem_ack = ack; alu_zero = z;
        @(posedge clk); #1;
    endtask

    task automatic fd(input logic [31:0] ins);
        instr = ins;
        cyc(0, 1, 0, S_IF, C_IF_A, FULL, "fetch");
        cyc(0, 0, 0, S_ID, C_ID,   FULL, "decode");
    endtask

    task automatic do_j(input logic [95:0] tag);
        instr = mk(J, 6'd0);
        cyc(0, 1, 0, S_IF, C_IF_A, FULL, tag);
        cyc(0, 0, 0, S_ID, C_ID_J, FULL, tag);
        exp_ret = exp_ret + 4'd1;
    endtask

    task automatic rst_cycle(input int st, input logic [21:0] c, input logic [21:0] m);
        cyc(1, 1, 0, st, c, m, "reset");
        exp_ret = '0; exp_trap = 1'b0; exp_cause = 2'b00;
    endtask

    initial begin
        reset = 1'b1; mem_ack = 1'b0; alu_zero = 1'b0; instr = mk(RT, 6'b100000);
        exp_ret = '0; exp_trap = 1'b0; exp_cause = 2'b00;
        @(posedge clk); #1;
        rst_cycle(S_IF, C_ZERO, ENMASK);

        instr = mk(RT, 6'b100000);
        cyc(0, 1, 0, S_IF, C_IF_A,   FULL, "add_if");
        cyc(0, 1, 0, S_ID, C_ID,     FULL, "add_id");
        cyc(0, 1, 0, S_EX, C_EX_ADD, FULL, "add_ex");
        cyc(0, 1, 0, S_WB, C_WB_R,   FULL, "add_wb");
        exp_ret = exp_ret + 4'd1;

        instr = mk(LW, 6'd0);
        cyc(0, 0, 0, S_IF,  C_IF_W,    FULL, "lw_if0");
        cyc(0, 0, 0, S_IF,  C_IF_W,    FULL, "lw_if1");
        cyc(0, 1, 0, S_IF,  C_IF_A,    FULL, "lw_if2");
        cyc(0, 0, 0, S_ID,  C_ID,      FULL, "lw_id");
        cyc(0, 0, 0, S_EX,  C_EX_ADDR, FULL, "lw_ex");
        cyc(0, 0, 0, S_MEM, C_MEM_LD,  FULL, "lw_mem0");
        cyc(0, 1, 0, S_MEM, C_MEM_LD,  FULL, "lw_mem1");
        cyc(0, 0, 0, S_WB,  C_WB_LW,   FULL, "lw_wb");
        exp_ret = exp_ret + 4'd1;

        fd(mk(BEQ, 6'd0)); cyc(0, 0, 1, S_EX, C_EX_BR_T, FULL, "beq_z1"); exp_ret = exp_ret + 4'd1;
        fd(mk(BEQ, 6'd0)); cyc(0, 0, 0, S_EX, C_EX_BR_N, FULL, "beq_z0"); exp_ret = exp_ret + 4'd1;
        fd(mk(BNE, 6'd0)); cyc(0, 0, 1, S_EX, C_EX_BR_N, FULL, "bne_z1"); exp_ret = exp_ret + 4'd1;
        fd(mk(BNE, 6'd0)); cyc(0, 0, 0, S_EX, C_EX_BR_T, FULL, "bne_z0"); exp_ret = exp_ret + 4'd1;

        fd(mk(SW, 6'd0));
        cyc(0, 0, 0, S_EX,  C_EX_ADDR, FULL, "sw_ex");
        cyc(0, 1, 0, S_MEM, C_MEM_ST,  FULL, "sw_mem");
        exp_ret = exp_ret + 4'd1;

        fd(mk(XORI, 6'd0));
        cyc(0, 0, 0, S_EX, C_EX_XORI, FULL, "xori_ex");
        cyc(0, 0, 0, S_WB, C_WB_I,    FULL, "xori_wb");
        exp_ret = exp_ret + 4'd1;

        fd(mk(ADDI, 6'b001000));
        cyc(0, 0, 0, S_EX, C_EX_ADDR, FULL, "addi_ex");
        cyc(0, 0, 0, S_WB, C_WB_I,    FULL, "addi_wb");
        exp_ret = exp_ret + 4'd1;

        fd(mk(RT, 6'b101010));
        cyc(0, 0, 0, S_EX, C_EX_SLT, FULL, "slt_ex");
        cyc(0, 0, 0, S_WB, C_WB_R,   FULL, "slt_wb");
        exp_ret = exp_ret + 4'd1;

        fd(mk(RT, 6'b100010));
        cyc(0, 0, 0, S_EX, C_EX_SUB, FULL, "sub_ex");
        cyc(0, 0, 0, S_WB, C_WB_R,   FULL, "sub_wb");
        exp_ret = exp_ret + 4'd1;

        fd(mk(JAL, 6'd0)); cyc(0, 0, 0, S_EX, C_EX_JAL, FULL, "jal_ex"); exp_ret = exp_ret + 4'd1;
        fd(mk(RT, 6'b001000)); cyc(0, 0, 0, S_EX, C_EX_JR, FULL, "jr_ex"); exp_ret = exp_ret + 4'd1;

        // 4-bit counter sits at 13 here; 17 jumps carry it through the wrap.
        for (int i = 0; i < 17; i++) do_j("j_loop");

        // Ack on the last allowed wait cycle beats the timeout.
        instr = mk(J, 6'd0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, S_IF, C_IF_W, FULL, "late_wait");
        cyc(0, 1, 0, S_IF, C_IF_A, FULL, "late_ack");
        cyc(0, 0, 0, S_ID, C_ID_J, FULL, "late_id");
        exp_ret = exp_ret + 4'd1;

        fd(mk(LW, 6'd0));
        cyc(0, 0, 0, S_EX,  C_EX_ADDR, FULL, "lwr_ex");
        cyc(0, 0, 0, S_MEM, C_MEM_LD,  FULL, "lwr_mem");
        rst_cycle(S_MEM, C_ZERO, ENMASK);
        cyc(0, 0, 0, S_IF, C_IF_W, FULL, "post_rst");

        instr = mk(6'b111111, 6'd0);
        cyc(0, 1, 0, S_IF, C_IF_A, FULL,   "ill_if");
        cyc(0, 1, 0, S_ID, C_ZERO, ENMASK, "ill_id");
        exp_trap = 1'b1; exp_cause = 2'b01;
        for (int i = 0; i < 20; i++) cyc(0, 1'(i), 1'(i >> 1), S_TRAP, C_ZERO, FULL, "ill_hold");
        rst_cycle(S_TRAP, C_ZERO, FULL);

        instr = mk(RT, 6'b000001);
        cyc(0, 1, 0, S_IF, C_IF_A, FULL,   "fn_if");
        cyc(0, 0, 0, S_ID, C_ZERO, ENMASK, "fn_id");
        exp_trap = 1'b1; exp_cause = 2'b01;
        cyc(0, 1, 0, S_TRAP, C_ZERO, FULL, "fn_hold");
        rst_cycle(S_TRAP, C_ZERO, FULL);

        do_j("pre_to");
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, S_IF, C_IF_W, FULL, "to_if");
        exp_trap = 1'b1; exp_cause = 2'b10;
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, S_TRAP, C_ZERO, FULL, "to_hold");
        rst_cycle(S_TRAP, C_ZERO, FULL);

        fd(mk(LW, 6'd0));
        cyc(0, 0, 0, S_EX, C_EX_ADDR, FULL, "mto_ex");
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, S_MEM, C_MEM_LD, FULL, "mto_mem");
        exp_trap = 1'b1; exp_cause = 2'b10;
        cyc(0, 1, 0, S_TRAP, C_ZERO, FULL, "mto_hold");
        rst_cycle(S_TRAP, C_ZERO, FULL);
        cyc(0, 0, 0, S_IF, C_IF_W, FULL, "final_if");

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: got %0d entries exp 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
